// File: rtl/rx_iq_fifo.sv
// Elastic I/Q buffer from the decimator to the I2S master; one pair is released per LRCLK frame.
// Optional build macro RXFIFO_TESTPAT_EN replaces write data with a ramp when test_mode=1.
module rx_iq_fifo #(
    parameter int DW          = 24,
    parameter int DEPTH_LOG2  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_real,
    input  logic [DW-1:0]         in_imag,
    input  logic                  lrclk,
    input  logic                  clear_flags,
    input  logic                  test_mode,
    output logic [DW-1:0]         out_real,
    output logic [DW-1:0]         out_imag,
    output logic                  out_update,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] PRIME_LVL = (DEPTH_LOG2+1)'(2**(DEPTH_LOG2-1));

    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [DW-1:0]          out_real_q, out_imag_q;
    logic                   out_update_q, overflow_q, underflow_q;
    logic [2*DW-1:0]        mem_q [DEPTH];
    logic [2*DW-1:0]        wdata, rd_data;
    logic                   frame, full, empty, pop, push_ok, ovf_evt, unf_evt;

    // in_valid is a one-cycle strobe with no back-pressure: a push into a full
    // FIFO is dropped unless a pop frees the slot on the same edge.
    assign frame   = hist_q & ~sync_q[SYNC_STAGES-1];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign push_ok = in_valid && (!full || pop);
    assign ovf_evt = in_valid && full && !pop;
    assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;
    end

`ifdef RXFIFO_TESTPAT_EN
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)      cnt_q <= '0;
        else if (push_ok) cnt_q <= cnt_q + DW'(1);
    end

    assign wdata = test_mode ? {cnt_q, ~cnt_q} : {in_real, in_imag};
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign wdata = {in_real, in_imag};
`endif

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) state_q <= S_FILL;
        else         state_q <= state_d;
    end

    // Priming is judged on the post-push occupancy of the current cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (level_d >= PRIME_LVL) state_d = S_RUN;
            S_RUN:   if (frame && empty)       state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        unf_evt = 1'b0;
        if (state_q == S_RUN && frame) begin
            if (empty) unf_evt = 1'b1;
            else       pop     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end

    // Synchronizer and history idle high so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sync_q       <= '1;
            hist_q       <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_real_q   <= '0;
            out_imag_q   <= '0;
            out_update_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], lrclk};
            hist_q       <= sync_q[SYNC_STAGES-1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_update_q <= pop;
            if (pop) begin
                out_real_q <= rd_data[2*DW-1:DW];
                out_imag_q <= rd_data[DW-1:0];
            end
            if (ovf_evt)          overflow_q  <= 1'b1;
            else if (clear_flags) overflow_q  <= 1'b0;
            if (unf_evt)          underflow_q <= 1'b1;
            else if (clear_flags) underflow_q <= 1'b0;
        end
    end

    assign out_real   = out_real_q;
    assign out_imag   = out_imag_q;
    assign out_update = out_update_q;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rx_iq_fifo.sv
// Self-checking bench for rx_iq_fifo: directed scenarios plus random push/frame traffic
// checked against a queue-based transaction model.
module tb_rx_iq_fifo;

    localparam int DW    = 24;
    localparam int DL    = 3;
    localparam int DEPTH = 8;
    localparam int PRIME = 4;

    logic            clk = 1'b0;
    logic            _reset = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_real = '0;
    logic [DW-1:0]   in_imag = '0;
    logic            lrclk = 1'b1;
    logic            clear_flags = 1'b0;
    logic            test_mode = 1'b0;
    logic [DW-1:0]   out_real, out_imag;
    logic            out_update;
    logic [DL:0]     level;
    logic            overflow, underflow, state_dbg;

    always #5 clk = ~clk;

    rx_iq_fifo #(.DW(DW), .DEPTH_LOG2(DL), .SYNC_STAGES(2)) dut (
        .clk(clk), ._reset(_reset), .in_valid(in_valid), .in_real(in_real),
        .in_imag(in_imag), .lrclk(lrclk), .clear_flags(clear_flags),
        .test_mode(test_mode), .out_real(out_real), .out_imag(out_imag),
        .out_update(out_update), .level(level), .overflow(overflow),
        .underflow(underflow), .state_dbg(state_dbg)
    );

    // Transaction-level reference model
    logic [2*DW-1:0] exp_q[$];
    bit              m_run, m_ovf, m_unf, m_pop;
    logic [DW-1:0]   m_real, m_imag, tp_cnt;
    int              checks = 0;
    int              errors = 0;
    int              upd_cnt;

    function automatic void model_reset();
        exp_q.delete();
        m_run = 0; m_ovf = 0; m_unf = 0; m_pop = 0;
        m_real = '0; m_imag = '0; tp_cnt = '0;
    endfunction

    function automatic void model_push(input logic [DW-1:0] r, input logic [DW-1:0] i);
        logic [2*DW-1:0] d;
        d = {r, i};
`ifdef RXFIFO_TESTPAT_EN
        if (test_mode) d = {tp_cnt, ~tp_cnt};
`endif
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
            tp_cnt = tp_cnt + 1'b1;
        end else begin
            m_ovf = 1;
        end
        if (!m_run && exp_q.size() >= PRIME) m_run = 1;
    endfunction

    function automatic void model_frame();
        logic [2*DW-1:0] d;
        m_pop = 0;
        if (m_run) begin
            if (exp_q.size() == 0) begin
                m_unf = 1;
                m_run = 0;
            end else begin
                d = exp_q.pop_front();
                m_real = d[2*DW-1:DW];
                m_imag = d[DW-1:0];
                m_pop = 1;
            end
        end
    endfunction

    // Drivers
    task automatic do_reset();
        @(posedge clk); #3;
        _reset = 1'b0;
        in_valid = 1'b0; clear_flags = 1'b0; lrclk = 1'b1;
        repeat (2) @(posedge clk);
        #1 _reset = 1'b1;
        model_reset();
    endtask

    task automatic do_push(input logic [DW-1:0] r, input logic [DW-1:0] i, input bit clr);
        @(posedge clk); #1;
        in_valid = 1'b1; in_real = r; in_imag = i; clear_flags = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; clear_flags = 1'b0;
        if (clr) begin m_ovf = 0; m_unf = 0; end
        model_push(r, i);
    endtask

    task automatic do_frame(input bit with_push, input logic [DW-1:0] r, input logic [DW-1:0] i);
        upd_cnt = 0;
        @(posedge clk); #1;
        lrclk = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2 && with_push) begin
                in_valid = 1'b1; in_real = r; in_imag = i;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_update === 1'b1) upd_cnt++;
        end
        lrclk = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_update === 1'b1) upd_cnt++;
        end
        model_frame();
        if (with_push) model_push(r, i);
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear_flags = 1'b1;
        @(posedge clk); #1 clear_flags = 1'b0;
        m_ovf = 0; m_unf = 0;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        checks++; if (out_real !== '0 || out_imag !== '0) begin errors++;
            $display("FAIL reset_out: got %h/%h want 0/0", out_real, out_imag); end
        checks++; if (level !== '0 || out_update !== 1'b0) begin errors++;
            $display("FAIL reset_level: got level=%0d upd=%b want 0/0", level, out_update); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || state_dbg !== 1'b0) begin errors++;
            $display("FAIL reset_flags: got ovf=%b unf=%b st=%b want 0/0/0", overflow, underflow, state_dbg); end
        for (int k = 0; k < 5; k++) do_push($urandom, $urandom, 1'b0);
        do_frame(1'b0, '0, '0);
        @(posedge clk); #3 _reset = 1'b0;
        #1;
        checks++; if (out_real !== '0 || level !== '0 || state_dbg !== 1'b0) begin errors++;
            $display("FAIL reset_async: got out=%h level=%0d st=%b want 0/0/0", out_real, level, state_dbg); end
        repeat (2) @(posedge clk);
        #1 _reset = 1'b1;
        model_reset();
    endtask

    task automatic test_prime();
        do_reset();
        for (int k = 1; k <= 3; k++) do_push(DW'(k), ~DW'(k), 1'b0);
        for (int k = 0; k < 2; k++) begin
            do_frame(1'b0, '0, '0);
            checks++; if (upd_cnt !== 0) begin errors++;
                $display("FAIL prime_noupd: got %0d pulses want 0", upd_cnt); end
        end
        checks++; if (level !== 4'd3 || underflow !== 1'b0 || state_dbg !== 1'b0) begin errors++;
            $display("FAIL prime_fill: got level=%0d unf=%b st=%b want 3/0/0", level, underflow, state_dbg); end
        checks++; if (out_real !== '0 || out_imag !== '0) begin errors++;
            $display("FAIL prime_hold: got %h/%h want 0/0", out_real, out_imag); end
        do_push(24'h000004, 24'hFFFFFB, 1'b0);
        checks++; if (state_dbg !== 1'b1) begin errors++;
            $display("FAIL prime_run: got st=%b want 1", state_dbg); end
        do_frame(1'b0, '0, '0);
        checks++; if (upd_cnt !== 1 || out_real !== 24'h000001 || out_imag !== 24'hFFFFFE) begin errors++;
            $display("FAIL prime_first: got upd=%0d %h/%h want 1 000001/fffffe", upd_cnt, out_real, out_imag); end
        checks++; if (level !== 4'(exp_q.size())) begin errors++;
            $display("FAIL prime_level: got %0d want %0d", level, exp_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            do_push(DW'(k), ~DW'(k), k == 10);
            checks++; if (overflow !== (k >= 9)) begin errors++;
                $display("FAIL ovf_flag_%0d: got %b want %b", k, overflow, (k >= 9)); end
        end
        checks++; if (level !== 4'd8 || m_ovf !== 1'b1) begin errors++;
            $display("FAIL ovf_level: got %0d want 8", level); end
        for (int k = 1; k <= 8; k++) begin
            do_frame(1'b0, '0, '0);
            checks++; if (upd_cnt !== 1 || out_real !== DW'(k) || out_imag !== m_imag) begin errors++;
                $display("FAIL ovf_drain_%0d: got upd=%0d %h/%h want 1 %h/%h", k, upd_cnt, out_real, out_imag, DW'(k), m_imag); end
        end
        do_clear();
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] r, i;
        do_reset();
        for (int k = 0; k < 8; k++) do_push($urandom, $urandom, 1'b0);
        r = $urandom; i = $urandom;
        do_frame(1'b1, r, i);
        checks++; if (level !== 4'd8 || overflow !== 1'b0 || upd_cnt !== 1) begin errors++;
            $display("FAIL fpp_level: got level=%0d ovf=%b upd=%0d want 8/0/1", level, overflow, upd_cnt); end
        checks++; if (out_real !== m_real || out_imag !== m_imag) begin errors++;
            $display("FAIL fpp_out: got %h/%h want %h/%h", out_real, out_imag, m_real, m_imag); end
        for (int k = 0; k < 8; k++) do_frame(1'b0, '0, '0);
        checks++; if (out_real !== r || out_imag !== i || level !== '0) begin errors++;
            $display("FAIL fpp_stored: got %h/%h lvl=%0d want %h/%h lvl=0", out_real, out_imag, level, r, i); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] hr, hi;
        hr = out_real; hi = out_imag;
        do_frame(1'b0, '0, '0);
        checks++; if (underflow !== 1'b1 || state_dbg !== 1'b0 || upd_cnt !== 0) begin errors++;
            $display("FAIL unf_flag: got unf=%b st=%b upd=%0d want 1/0/0", underflow, state_dbg, upd_cnt); end
        checks++; if (out_real !== hr || out_imag !== hi) begin errors++;
            $display("FAIL unf_hold: got %h/%h want %h/%h", out_real, out_imag, hr, hi); end
        do_clear();
        checks++; if (underflow !== 1'b0) begin errors++;
            $display("FAIL unf_clear: got %b want 0", underflow); end
    endtask

    task automatic test_testpat();
        do_reset();
        test_mode = 1'b1;
        for (int k = 0; k < 6; k++) do_push($urandom, $urandom, 1'b0);
        for (int k = 0; k < 2; k++) begin
            do_frame(1'b0, '0, '0);
            checks++; if (out_real !== m_real || out_imag !== m_imag) begin errors++;
                $display("FAIL tp_model_%0d: got %h/%h want %h/%h", k, out_real, out_imag, m_real, m_imag); end
`ifdef RXFIFO_TESTPAT_EN
            checks++; if (out_real !== DW'(k) || out_imag !== ~DW'(k)) begin errors++;
                $display("FAIL tp_ramp_%0d: got %h/%h want %h/%h", k, out_real, out_imag, DW'(k), ~DW'(k)); end
`endif
        end
        test_mode = 1'b0;
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4)      do_push($urandom, $urandom, 1'b0);
            else if (op <= 8) begin
                do_frame(1'b0, '0, '0);
                checks++; if (upd_cnt !== int'(m_pop)) begin errors++;
                    $display("FAIL rnd_upd_%0d: got %0d want %0d", n, upd_cnt, m_pop); end
            end else do_clear();
            checks++; if (level !== 4'(exp_q.size()) || state_dbg !== m_run) begin errors++;
                $display("FAIL rnd_level_%0d: got lvl=%0d st=%b want %0d/%b", n, level, state_dbg, exp_q.size(), m_run); end
            checks++; if (overflow !== m_ovf || underflow !== m_unf) begin errors++;
                $display("FAIL rnd_flags_%0d: got %b%b want %b%b", n, overflow, underflow, m_ovf, m_unf); end
            checks++; if (out_real !== m_real || out_imag !== m_imag) begin errors++;
                $display("FAIL rnd_out_%0d: got %h/%h want %h/%h", n, out_real, out_imag, m_real, m_imag); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prime();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_testpat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
